// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with jump, skip, hold and a circular call/return stack
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   advance               qualifies an update; state holds when low
//   op[2:0], target       operation select and JUMP/CALL destination
//   pc                    registered program counter
//   flush                 one-cycle pulse marking the fetched instruction invalid
//   depth                 occupied return-stack entries, 0..STACK_DEPTH
//   stack_overflow/underflow  sticky push-while-full / pop-while-empty flags
// Optional feature macro PC_STACK_INTERRUPT_EN adds int_req, gie_set, gie and op 6 RETFIE.
module pc_stack_unit #(
    parameter int PC_W         = 13,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0,
    parameter int INT_VECTOR   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           advance,
    input  logic [2:0]                     op,
    input  logic [PC_W-1:0]                target,
`ifdef PC_STACK_INTERRUPT_EN
    input  logic                           int_req,
    input  logic                           gie_set,
    output logic                           gie,
`endif
    output logic [PC_W-1:0]                pc,
    output logic                           flush,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);
    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam int D_W  = SP_W + 1;
    localparam logic [2:0] OP_JUMP = 3'd1, OP_CALL = 3'd2, OP_RET = 3'd3;
    localparam logic [2:0] OP_SKIP = 3'd4, OP_HOLD = 3'd5, OP_RETFIE = 3'd6;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp, sp_dec;
    logic [PC_W-1:0] pc_nx, push_val;
    logic            take_int, retfie, push, pop, full, empty, flush_nx;
`ifdef PC_STACK_INTERRUPT_EN
    assign take_int = int_req & gie;
    assign retfie   = !take_int && op == OP_RETFIE;
`else
    assign take_int = 1'b0;
    assign retfie   = 1'b0;
`endif
    always_comb begin
        sp_dec   = sp - SP_W'(1);
        full     = depth == D_W'(STACK_DEPTH);
        empty    = depth == '0;
        push     = take_int || op == OP_CALL;
        pop      = !take_int && (op == OP_RET || retfie);
        // an interrupt re-executes the interrupted instruction, so it saves pc itself
        push_val = take_int ? pc : pc + PC_W'(1);
        pc_nx    = take_int ? PC_W'(INT_VECTOR) :
                   (op == OP_JUMP || op == OP_CALL) ? target :
                   pop ? stack[sp_dec] :
                   op == OP_SKIP ? pc + PC_W'(2) :
                   op == OP_HOLD ? pc : pc + PC_W'(1);
        flush_nx = push || pop || op == OP_JUMP || op == OP_SKIP;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc              <= PC_W'(RESET_VECTOR);
            flush           <= 1'b0;
            depth           <= '0;
            sp              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
`ifdef PC_STACK_INTERRUPT_EN
            gie             <= 1'b1;
`endif
        end else if (advance) begin
            pc    <= pc_nx;
            flush <= flush_nx;
            if (push) begin
                // a full stack keeps wrapping, overwriting the oldest entry
                stack[sp] <= push_val;
                sp        <= sp + SP_W'(1);
                if (full) stack_overflow <= 1'b1;
                else depth <= depth + D_W'(1);
            end else if (pop) begin
                sp <= sp_dec;
                if (empty) stack_underflow <= 1'b1;
                else depth <= depth - D_W'(1);
            end
`ifdef PC_STACK_INTERRUPT_EN
            if (take_int) gie <= 1'b0;
            else if (retfie || gie_set) gie <= 1'b1;
`endif
        end else begin
            flush <= 1'b0;
        end
    end
endmodule
